// File: rtl/bram_pkg.sv
// Shared BRAM port-B definitions: bus widths and the burst engine state encoding.
package bram_pkg;

    // Bus widths shared with the BRAM interface controller
    localparam int BRAM_ADDR_W = 17;
    localparam int BRAM_DATA_W = 8;

    // Burst engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage : bram_pkg

// File: rtl/bram_burst_master_fifo.sv
// Small synchronous FIFO for the read return path.
// The output is taken from the storage flops, so data pushed in one cycle
// is presented in the next cycle and never in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Push is allowed when full only if a pop frees a slot in the same cycle
    always_comb begin
        full     = (count_reg == CNT_W'(DEPTH));
        empty    = (count_reg == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem_reg[rd_ptr_reg];
        count    = count_reg;
    end

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/bram_burst_master.sv
// Burst engine driving the BRAM port-B controller one byte per cycle.
// Writes are fed from a valid/ready stream; reads return through a
// credit-limited FIFO so consumer backpressure never loses a byte.
module bram_burst_master
    import bram_pkg::*;
#(
    parameter int ADDR_W     = BRAM_ADDR_W,
    parameter int DATA_W     = BRAM_DATA_W,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_rvalid,
    input  logic              m_rready,
    output logic              m_rlast,
    output logic              busy,
    output logic              done,
    output logic              en,
    output logic              wr,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] wdata_out,
    input  logic [DATA_W-1:0] rdata_in,
    input  logic              rdata_rdy
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W = DATA_W + 1;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W:0]    len_ext;
    logic [LEN_W:0]    issue_cnt_reg;
    logic [LEN_W:0]    ret_cnt_reg;
    logic              inflight_reg;
    logic              done_reg;
    logic              busy_reg;
    logic [ADDR_W-1:0] addr_cur;

    logic              cmd_fire;
    logic              wr_fire;
    logic              wr_last;
    logic              rd_issue;
    logic              ret_ok;
    logic              ret_last;

    logic              fifo_pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [FIFO_W-1:0] fifo_dout;

    assign len_ext  = {1'b0, len_reg};
    // Natural modulo-2^ADDR_W wrap of the byte address
    assign addr_cur = base_reg + ADDR_W'(issue_cnt_reg);

    // Handshakes, read credit and return acceptance
    always_comb begin
        cmd_ready = (state_reg == IDLE);
        s_wready  = (state_reg == WRITE);
        cmd_fire  = cmd_valid && (state_reg == IDLE);
        wr_fire   = s_wvalid && (state_reg == WRITE);
        wr_last   = wr_fire && (issue_cnt_reg == len_ext);
        // A read may only be issued if its byte is guaranteed a FIFO slot,
        // counting the byte still in flight from last cycle's issue.
        rd_issue  = (state_reg == READ) && (issue_cnt_reg <= len_ext) &&
                    ((fifo_count + CNT_W'(inflight_reg)) < CNT_W'(FIFO_DEPTH));
        // Returns outside READ or past the burst length are dropped
        ret_ok    = (state_reg == READ) && rdata_rdy && (ret_cnt_reg <= len_ext);
        ret_last  = ret_ok && (ret_cnt_reg == len_ext);
    end

    // BRAM controller bus, zeroed whenever nothing is issued
    always_comb begin
        en        = wr_fire || rd_issue;
        wr        = wr_fire;
        addr_out  = (wr_fire || rd_issue) ? addr_cur : '0;
        wdata_out = wr_fire ? s_wdata : '0;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_fire) state_next = cmd_wr ? WRITE : READ;
            WRITE:   if (wr_last)  state_next = IDLE;
            READ:    if (ret_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command latch, issue/return counters and registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg      <= '0;
            len_reg       <= '0;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            inflight_reg  <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            if (cmd_fire) begin
                base_reg      <= cmd_addr;
                len_reg       <= cmd_len;
                issue_cnt_reg <= '0;
                ret_cnt_reg   <= '0;
            end else begin
                if (wr_fire || rd_issue) begin
                    issue_cnt_reg <= issue_cnt_reg + 1'b1;
                end
                if (ret_ok) begin
                    ret_cnt_reg <= ret_cnt_reg + 1'b1;
                end
            end
            inflight_reg <= rd_issue;
            done_reg     <= wr_last || ret_last;
            busy_reg     <= (state_next != IDLE);
        end
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ret_ok),
        .push_data ({ret_last, rdata_in}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Read return stream; data and last are masked while the FIFO is empty
    always_comb begin
        fifo_pop = !fifo_empty && m_rready;
        m_rvalid = !fifo_empty;
        m_rdata  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
        m_rlast  = !fifo_empty && fifo_dout[DATA_W];
        busy     = busy_reg;
        done     = done_reg;
    end

endmodule : bram_burst_master

// File: tb/tb_bram_burst_master.sv
// Bench for bram_burst_master: BRAM model, scoreboards and directed + random bursts.
module tb_bram_burst_master;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int MEM_SIZE   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] s_wdata;
    logic              s_wvalid, s_wready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid, m_rready, m_rlast;
    logic              busy, done, en, wr;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] wdata_out;
    logic [DATA_W-1:0] rdata_in;
    logic              rdata_rdy;

    bram_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
        .busy(busy), .done(done), .en(en), .wr(wr),
        .addr_out(addr_out), .wdata_out(wdata_out),
        .rdata_in(rdata_in), .rdata_rdy(rdata_rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
    } issue_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } rd_t;

    issue_t     issue_q[$];
    rd_t        exp_rd_q[$];
    logic [7:0] wq[$];
    logic [7:0] bram_mem [MEM_SIZE];
    logic [7:0] ref_mem  [MEM_SIZE];

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   rd_pop_cnt = 0;
    int   outstanding = 0;
    int   rmode = 0;
    int   wmode = 0;
    logic stray = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // BRAM controller model: write in the issue cycle, read data one cycle later
    always @(posedge clk) begin
        if (en && wr) bram_mem[addr_out] <= wdata_out;
        rdata_rdy <= (en && !wr) || stray;
        rdata_in  <= bram_mem[addr_out];
    end

    // Read consumer
    initial begin
        m_rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1:       m_rready = 1'b1;
                2:       m_rready = 1'($urandom_range(0, 1));
                default: m_rready = 1'b0;
            endcase
        end
    end

    // Write byte source
    initial begin
        s_wvalid = 1'b0;
        s_wdata  = '0;
        forever begin
            @(posedge clk); #1;
            if (wq.size() > 0 && (wmode == 1 || (wmode == 2 && $urandom_range(0, 1) == 1))) begin
                s_wvalid = 1'b1;
                s_wdata  = wq[0];
            end else begin
                s_wvalid = 1'b0;
                s_wdata  = 8'($urandom);
            end
        end
    end

    // Monitor: issue addresses, write bytes, read return order, credit and done pulses
    always @(negedge clk) begin
        issue_t e;
        rd_t    r;
        logic [7:0] b;
        if (!rst) begin
            if (en) begin
                if (issue_q.size() == 0) begin
                    check_val("en_unexpected", 1, 0);
                end else begin
                    e = issue_q.pop_front();
                    check_val("issue_addr", addr_out, e.addr);
                    check_val("issue_dir", wr, e.wr);
                end
                if (!wr) begin
                    outstanding++;
                    check_val("read_credit", outstanding <= FIFO_DEPTH, 1);
                end
            end
            if (s_wvalid && s_wready) begin
                if (wq.size() == 0) begin
                    check_val("wbyte_unexpected", 1, 0);
                end else begin
                    b = wq.pop_front();
                    check_val("wdata_out", wdata_out, b);
                end
            end
            if (m_rvalid && m_rready) begin
                outstanding--;
                rd_pop_cnt++;
                if (exp_rd_q.size() == 0) begin
                    check_val("rbyte_unexpected", 1, 0);
                end else begin
                    r = exp_rd_q.pop_front();
                    check_val("rdata", m_rdata, r.data);
                    check_val("rlast", m_rlast, r.last);
                end
            end
            if (done) done_cnt++;
        end
    end

    // Build expectations from the reference memory, then handshake the command
    task automatic send_cmd(input logic wr_i, input logic [ADDR_W-1:0] addr_i,
                            input int len_i, input bit fixed);
        issue_t            e;
        rd_t               r;
        logic [ADDR_W-1:0] a;
        logic [7:0]        b;
        int                t;
        $display("cmd %s addr=%05h len=%0d", wr_i ? "WR" : "RD", addr_i, len_i);
        for (int i = 0; i <= len_i; i++) begin
            a      = addr_i + ADDR_W'(i);
            e.wr   = wr_i;
            e.addr = a;
            issue_q.push_back(e);
            if (wr_i) begin
                b = fixed ? 8'(8'hAA + i * 8'h11) : 8'($urandom);
                ref_mem[a] = b;
                wq.push_back(b);
            end else begin
                r.data = ref_mem[a];
                r.last = (i == len_i);
                exp_rd_q.push_back(r);
            end
        end
        @(posedge clk); #1;
        cmd_wr    = wr_i;
        cmd_addr  = addr_i;
        cmd_len   = LEN_W'(len_i);
        cmd_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            t++;
            if (t > 3000) begin
                check_val("cmd_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check_val("done_timeout", done_cnt >= target, 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_rd_q.size() + issue_q.size() + wq.size()) != 0 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check_val("drain", exp_rd_q.size() + issue_q.size() + wq.size(), 0);
    endtask

    task automatic clear_model();
        issue_q.delete();
        exp_rd_q.delete();
        wq.delete();
        outstanding = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               d0;
        int               n_en;
        int               p0;
        logic [ADDR_W-1:0] a;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            bram_mem[i] = 8'(i * 7 + 3);
            ref_mem[i]  = 8'(i * 7 + 3);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_val("rst_en", en, 0);
        check_val("rst_wr", wr, 0);
        check_val("rst_s_wready", s_wready, 0);
        check_val("rst_m_rvalid", m_rvalid, 0);
        check_val("rst_m_rlast", m_rlast, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_addr_out", addr_out, 0);
        check_val("rst_wdata_out", wdata_out, 0);
        check_val("rst_cmd_ready", cmd_ready, 1);

        // Write burst AA..DD at 0x100, s_wvalid held high
        wmode = 1;
        d0 = done_cnt;
        send_cmd(1'b1, 17'h00100, 3, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check_val("wr_en", en, c <= 4);
            check_val("wr_wr", wr, c <= 4);
            check_val("wr_busy", busy, c <= 4);
            check_val("wr_done", done, c == 5);
        end
        @(negedge clk);
        check_val("wr_done_once", done_cnt - d0, 1);
        for (int i = 0; i < 4; i++) begin
            check_val("bram_content", bram_mem[17'h00100 + i], 8'(8'hAA + i * 8'h11));
        end

        // Read burst back with no backpressure, cycle-exact timing
        rmode = 1;
        d0 = done_cnt;
        send_cmd(1'b0, 17'h00100, 3, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check_val("rd_en", en, c <= 4);
            check_val("rd_m_rvalid", m_rvalid, c >= 3 && c <= 6);
            check_val("rd_m_rlast", m_rlast, c == 6);
            check_val("rd_done", done, c == 6);
            check_val("rd_busy", busy, c <= 5);
            if (c >= 3 && c <= 6) check_val("rd_byte", m_rdata, 8'(8'hAA + (c - 3) * 8'h11));
        end
        check_val("rd_done_once", done_cnt - d0, 1);
        wait_drain();

        // Backpressure: consumer stalled for 10 cycles after the first issue
        rmode = 0;
        d0 = done_cnt;
        send_cmd(1'b0, 17'($urandom), 15, 1'b0);
        n_en = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (en) n_en++;
        end
        check_val("bp_issues", n_en, FIFO_DEPTH);
        check_val("bp_en_stalled", en, 0);
        check_val("bp_m_rvalid", m_rvalid, 1);
        p0 = rd_pop_cnt;
        rmode = 1;
        wait_done(d0 + 1);
        wait_drain();
        check_val("bp_bytes", rd_pop_cnt - p0, 16);

        // Address wrap at the top of the BRAM, read and write
        rmode = 2;
        wmode = 2;
        d0 = done_cnt;
        send_cmd(1'b1, 17'h1FFFD, 4, 1'b0);
        wait_done(d0 + 1);
        send_cmd(1'b0, 17'h1FFFE, 3, 1'b0);
        wait_done(d0 + 2);
        wait_drain();

        // Reset in the cycle of the third read issue, then stale and stray returns
        rmode = 0;
        a = 17'($urandom);
        send_cmd(1'b0, a, 7, 1'b0);
        n_en = 0;
        for (int t = 0; t < 50 && n_en < 3; t++) begin
            @(negedge clk);
            if (en) n_en++;
        end
        check_val("rr_third_issue", n_en, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 1'b1;
        clear_model();
        @(negedge clk);
        check_val("rr_en", en, 0);
        check_val("rr_m_rvalid", m_rvalid, 0);
        check_val("rr_cmd_ready", cmd_ready, 1);
        check_val("rr_busy", busy, 0);
        check_val("rr_stale_rdy", rdata_rdy, 1);
        @(posedge clk); #1;
        stray = 1'b0;
        @(negedge clk);
        check_val("rr_no_stale_push", m_rvalid, 0);
        check_val("rr_en2", en, 0);
        @(negedge clk);
        check_val("rr_no_stray_push", m_rvalid, 0);
        rmode = 1;
        d0 = done_cnt;
        p0 = rd_pop_cnt;
        send_cmd(1'b0, a, 0, 1'b0);
        wait_done(d0 + 1);
        wait_drain();
        check_val("rr_single_byte", rd_pop_cnt - p0, 1);

        // Back-to-back: read len=1, then write len=1 while read data waits
        rmode = 0;
        wmode = 1;
        a = 17'($urandom);
        d0 = done_cnt;
        p0 = rd_pop_cnt;
        send_cmd(1'b0, a, 1, 1'b0);
        send_cmd(1'b1, a + 17'h40, 1, 1'b0);
        wait_done(d0 + 2);
        @(negedge clk);
        check_val("b2b_undrained", m_rvalid, 1);
        check_val("b2b_writes_done", wq.size(), 0);
        rmode = 1;
        wait_drain();
        check_val("b2b_read_bytes", rd_pop_cnt - p0, 2);

        // Random bursts with random stream pacing
        for (int n = 0; n < 40; n++) begin
            rmode = $urandom_range(1, 2);
            wmode = $urandom_range(1, 2);
            a = ($urandom_range(0, 3) == 0) ? 17'(17'h1FFF0 + $urandom_range(0, 15)) : 17'($urandom);
            d0 = done_cnt;
            send_cmd(1'($urandom_range(0, 1)), a, $urandom_range(0, 20), 1'b0);
            wait_done(d0 + 1);
        end
        rmode = 1;
        wait_drain();
        repeat (4) @(negedge clk);
        check_val("final_outstanding", outstanding, 0);
        check_val("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bram_burst_master
